// File: rtl/merge_logic_pkg.sv
// Shared constants and FSM encoding for the two-source merge block.
package merge_logic_pkg;

  localparam int DATA_WIDTH_DEF = 6;
  localparam int ADDR_WIDTH_DEF = 2;

  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_INIT   = 3'd1,
    ST_IDLE   = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_ERROR  = 3'd4
  } state_t;

  // Traffic is only accepted once thresholds have been loaded.
  function automatic logic is_open(input state_t s);
    return (s == ST_IDLE) || (s == ST_ACTIVE) || (s == ST_ERROR);
  endfunction

endpackage

// File: rtl/merge_logic_fifo_sync.sv
// Synchronous FIFO with occupancy count and a threshold-based almost-full flag.
module fifo_sync
  import merge_logic_pkg::*;
#(
  parameter int data_width    = DATA_WIDTH_DEF,
  parameter int address_width = ADDR_WIDTH_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [data_width-1:0]    din,
  input  logic [address_width:0]   threshold,
  input  logic                     flag_enable,
  output logic [data_width-1:0]    dout,
  output logic [address_width:0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full
);

  localparam int DEPTH = 1 << address_width;

  logic [data_width-1:0]    mem [DEPTH];
  logic [address_width-1:0] wr_ptr;
  logic [address_width-1:0] rd_ptr;
  logic                     do_push;
  logic                     do_pop;

  // A full FIFO still takes a write when the same edge frees a slot.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign dout        = mem[rd_ptr];
  assign full        = (count == (address_width+1)'(DEPTH));
  assign empty       = (count == '0);
  // Threshold 0 naturally forces the flag, since count >= 0 always holds.
  assign almost_full = flag_enable && (count >= threshold);

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + address_width'(1);
      if (do_pop)  rd_ptr <= rd_ptr + address_width'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (address_width+1)'(1);
        2'b01:   count <= count - (address_width+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents are don't-care while count says empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/merge_logic.sv
// Merges two source FIFOs into one output FIFO through a round-robin arbiter.
//
//   state     | meaning
//   ----------+-----------------------------------------------------
//   ST_RESET  | held in reset, all traffic ignored
//   ST_INIT   | thresholds captured while init=1, traffic ignored
//   ST_IDLE   | all three FIFOs empty
//   ST_ACTIVE | at least one FIFO holds data
//   ST_ERROR  | overflow or empty pop seen; sticky until reset
module merge_logic
  import merge_logic_pkg::*;
#(
  parameter int data_width    = DATA_WIDTH_DEF,
  parameter int address_width = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  init,
  input  logic [3:0]            umbral_Ds,
  input  logic [3:0]            umbral_MF,
  input  logic                  push_D0,
  input  logic                  push_D1,
  input  logic [data_width-1:0] data_in_D0,
  input  logic [data_width-1:0] data_in_D1,
  input  logic                  pop_out,
  output logic [data_width-1:0] data_out,
  output logic                  valid_out,
  output logic                  empty_out,
  output logic                  almost_full_out,
  output logic                  almost_full_D0,
  output logic                  almost_full_D1,
  output logic                  idle_out,
  output logic                  active_out,
  output logic                  error_out
);

  localparam int DEPTH = 1 << address_width;
  localparam int CW    = address_width + 1;

  state_t                state, state_next;
  logic [CW-1:0]         thr_ds, thr_mf, ds_sat, mf_sat;
  logic                  open, rr_d1, gnt0, gnt1, arb_push;
  logic                  push0, push1, pop_ok, error_event;
  logic [data_width-1:0] dout0, dout1, dout_m, arb_data;
  logic [CW-1:0]         count0, count1, count_m;
  logic                  full0, full1, full_m, empty0, empty1, empty_m;

  assign open = is_open(state);

  // Clamp raw thresholds to the FIFO depth before they are captured.
  always_comb begin
    ds_sat = (int'(umbral_Ds) > DEPTH) ? CW'(DEPTH) : CW'(umbral_Ds);
    mf_sat = (int'(umbral_MF) > DEPTH) ? CW'(DEPTH) : CW'(umbral_MF);
  end

  // Round-robin grant; only contested cycles consult the pointer.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!full_m) begin
      if (!empty0 && !empty1) begin
        gnt0 = !rr_d1;
        gnt1 = rr_d1;
      end else begin
        gnt0 = !empty0;
        gnt1 = !empty1;
      end
    end
  end

  assign arb_push = gnt0 || gnt1;
  assign arb_data = gnt1 ? dout1 : dout0;
  assign push0    = push_D0 && open;
  assign push1    = push_D1 && open;
  assign pop_ok   = pop_out && open && !empty_m;

  assign error_event = (push0 && full0 && !gnt0) ||
                       (push1 && full1 && !gnt1) ||
                       (pop_out && open && empty_m);

  fifo_sync #(.data_width(data_width), .address_width(address_width)) u_fifo_d0 (
    .clk(clk), .reset(reset), .push(push0), .pop(gnt0), .din(data_in_D0),
    .threshold(thr_ds), .flag_enable(open), .dout(dout0), .count(count0),
    .full(full0), .empty(empty0), .almost_full(almost_full_D0)
  );

  fifo_sync #(.data_width(data_width), .address_width(address_width)) u_fifo_d1 (
    .clk(clk), .reset(reset), .push(push1), .pop(gnt1), .din(data_in_D1),
    .threshold(thr_ds), .flag_enable(open), .dout(dout1), .count(count1),
    .full(full1), .empty(empty1), .almost_full(almost_full_D1)
  );

  fifo_sync #(.data_width(data_width), .address_width(address_width)) u_fifo_main (
    .clk(clk), .reset(reset), .push(arb_push), .pop(pop_ok), .din(arb_data),
    .threshold(thr_mf), .flag_enable(open), .dout(dout_m), .count(count_m),
    .full(full_m), .empty(empty_m), .almost_full(almost_full_out)
  );

  assign empty_out = empty_m;

  // Next-state logic; errors win over the idle/active occupancy decision.
  always_comb begin
    state_next = state;
    case (state)
      ST_RESET: state_next = ST_INIT;
      ST_INIT:  if (!init) state_next = ST_IDLE;
      ST_IDLE, ST_ACTIVE: begin
        if (error_event)                          state_next = ST_ERROR;
        else if (|{count0, count1, count_m})      state_next = ST_ACTIVE;
        else                                      state_next = ST_IDLE;
      end
      ST_ERROR: state_next = ST_ERROR;
      default:  state_next = ST_RESET;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_RESET;
    else       state <= state_next;
  end

  // Threshold capture and round-robin pointer (pointer set means D1 is next).
  always_ff @(posedge clk) begin
    if (reset) begin
      thr_ds <= '0;
      thr_mf <= '0;
      rr_d1  <= 1'b0;
    end else begin
      if (state == ST_INIT && init) begin
        thr_ds <= ds_sat;
        thr_mf <= mf_sat;
      end
      if (gnt0)      rr_d1 <= 1'b1;
      else if (gnt1) rr_d1 <= 1'b0;
    end
  end

  // Registered read port; data_out holds its last word between pops.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_out  <= '0;
      valid_out <= 1'b0;
    end else begin
      valid_out <= pop_ok;
      if (pop_ok) data_out <= dout_m;
    end
  end

  assign idle_out   = (state == ST_IDLE);
  assign active_out = (state == ST_ACTIVE);
  assign error_out  = (state == ST_ERROR);

endmodule

// File: tb/tb_merge_logic.sv
// Scoreboard bench for merge_logic: queue-based reference model plus monitor.
module tb_merge_logic;

  localparam int DW = 6;
  localparam int DEPTH = 4;
  localparam int P_RESET = 0, P_INIT = 1, P_IDLE = 2, P_ACTIVE = 3, P_ERROR = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          init = 1'b0;
  logic [3:0]    umbral_Ds = '0, umbral_MF = '0;
  logic          push_D0 = 1'b0, push_D1 = 1'b0, pop_out = 1'b0;
  logic [DW-1:0] data_in_D0 = '0, data_in_D1 = '0;
  logic [DW-1:0] data_out;
  logic          valid_out, empty_out, almost_full_out, almost_full_D0, almost_full_D1;
  logic          idle_out, active_out, error_out;

  merge_logic #(.data_width(DW), .address_width(2)) dut (
    .clk(clk), .reset(reset), .init(init), .umbral_Ds(umbral_Ds), .umbral_MF(umbral_MF),
    .push_D0(push_D0), .push_D1(push_D1), .data_in_D0(data_in_D0), .data_in_D1(data_in_D1),
    .pop_out(pop_out), .data_out(data_out), .valid_out(valid_out), .empty_out(empty_out),
    .almost_full_out(almost_full_out), .almost_full_D0(almost_full_D0),
    .almost_full_D1(almost_full_D1), .idle_out(idle_out), .active_out(active_out),
    .error_out(error_out)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  int q0[$], q1[$], qm[$];
  int expq[$];
  int phase = P_RESET;
  int rr = 0;
  int thr_ds = 0, thr_mf = 0;
  int m_valid = 0, m_data = 0;

  function automatic int sat(input int v);
    return (v > DEPTH) ? DEPTH : v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: one transaction-level step per rising edge.
  initial forever begin
    @(posedge clk);
    if (reset) begin
      q0.delete(); q1.delete(); qm.delete();
      rr = 0; phase = P_RESET; thr_ds = 0; thr_mf = 0;
      m_valid = 0; m_data = 0;
    end else begin
      bit open, err, busy, room, has_w;
      int w;
      open  = (phase >= P_IDLE);
      busy  = (q0.size() + q1.size() + qm.size()) > 0;
      room  = qm.size() < DEPTH;
      err   = 0;
      has_w = 0;
      w     = 0;
      if (room && (q0.size() > 0 || q1.size() > 0)) begin
        if (q0.size() > 0 && (q1.size() == 0 || rr == 0)) begin
          w = q0.pop_front(); rr = 1;
        end else begin
          w = q1.pop_front(); rr = 0;
        end
        has_w = 1;
      end
      m_valid = 0;
      if (open && pop_out) begin
        if (qm.size() > 0) begin
          m_data = qm.pop_front();
          m_valid = 1;
          expq.push_back(m_data);
        end else err = 1;
      end
      if (open && push_D0) begin
        if (q0.size() < DEPTH) q0.push_back(int'(data_in_D0)); else err = 1;
      end
      if (open && push_D1) begin
        if (q1.size() < DEPTH) q1.push_back(int'(data_in_D1)); else err = 1;
      end
      if (has_w) qm.push_back(w);
      case (phase)
        P_RESET: phase = P_INIT;
        P_INIT: begin
          if (init) begin
            thr_ds = sat(int'(umbral_Ds));
            thr_mf = sat(int'(umbral_MF));
          end else phase = P_IDLE;
        end
        P_IDLE, P_ACTIVE: phase = err ? P_ERROR : (busy ? P_ACTIVE : P_IDLE);
        default: phase = P_ERROR;
      endcase
    end
  end

  // Monitor: compare DUT outputs against the model between edges.
  initial forever begin
    bit on;
    @(negedge clk);
    on = (phase >= P_IDLE);
    chk("valid_out", int'(valid_out), m_valid);
    chk("data_out", int'(data_out), m_data);
    chk("empty_out", int'(empty_out), int'(qm.size() == 0));
    chk("almost_full_D0", int'(almost_full_D0), int'(on && q0.size() >= thr_ds));
    chk("almost_full_D1", int'(almost_full_D1), int'(on && q1.size() >= thr_ds));
    chk("almost_full_out", int'(almost_full_out), int'(on && qm.size() >= thr_mf));
    chk("idle_out", int'(idle_out), int'(phase == P_IDLE));
    chk("active_out", int'(active_out), int'(phase == P_ACTIVE));
    chk("error_out", int'(error_out), int'(phase == P_ERROR));
    if (valid_out) begin
      if (expq.size() == 0) chk("sb_unexpected_word", int'(data_out), -1);
      else chk("sb_word", int'(data_out), expq.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic quiet();
    push_D0 = 1'b0; push_D1 = 1'b0; pop_out = 1'b0;
  endtask

  // Reset, then load thresholds; random traffic in INIT must be ignored.
  task automatic reset_init(input int ds, input int mf);
    quiet(); init = 1'b0; reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    tick();
    umbral_Ds = 4'(ds); umbral_MF = 4'(mf); init = 1'b1;
    for (int i = 0; i < 2; i++) begin
      push_D0 = 1'($urandom_range(0, 1)); data_in_D0 = DW'($urandom_range(0, 63));
      push_D1 = 1'($urandom_range(0, 1)); data_in_D1 = DW'($urandom_range(0, 63));
      pop_out = 1'($urandom_range(0, 1));
      tick();
    end
    quiet(); init = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    int pp, pq;
    reset_init(2, 3);

    // Single word end to end.
    push_D0 = 1'b1; data_in_D0 = 6'b001000; tick();
    quiet(); tick();
    pop_out = 1'b1; tick();
    quiet(); repeat (3) tick();

    // Interleaving of simultaneous sources: expect A, C, B, D.
    push_D0 = 1'b1; data_in_D0 = 6'd10; push_D1 = 1'b1; data_in_D1 = 6'd30; tick();
    data_in_D0 = 6'd11; data_in_D1 = 6'd31; tick();
    quiet(); repeat (3) tick();
    pop_out = 1'b1; repeat (4) tick();
    quiet(); repeat (3) tick();

    // Pop on empty output FIFO.
    pop_out = 1'b1; tick();
    quiet(); repeat (2) tick();

    // Overflow D0 with no reads until a push is dropped.
    reset_init(2, 3);
    for (int i = 0; i < 9; i++) begin
      push_D0 = 1'b1; data_in_D0 = DW'(i + 1); tick();
    end
    quiet(); repeat (3) tick();
    pop_out = 1'b1; repeat (3) tick();
    quiet(); tick();

    // Reset with words in flight.
    reset_init(2, 3);
    for (int i = 0; i < 3; i++) begin
      push_D0 = 1'b1; data_in_D0 = DW'(40 + i);
      push_D1 = (i == 1); data_in_D1 = 6'd50; tick();
    end
    quiet(); tick();
    reset_init(2, 3);
    repeat (2) tick();

    // Randomized epochs including threshold extremes.
    for (int e = 0; e < 6; e++) begin
      if (e == 0)      reset_init(0, 0);
      else if (e == 1) reset_init(15, 9);
      else             reset_init(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
      pp = int'($urandom_range(20, 70));
      pq = int'($urandom_range(20, 80));
      for (int c = 0; c < 250; c++) begin
        push_D0 = ($urandom_range(0, 99) < pp); data_in_D0 = DW'($urandom_range(0, 63));
        push_D1 = ($urandom_range(0, 99) < pp); data_in_D1 = DW'($urandom_range(0, 63));
        pop_out = ($urandom_range(0, 99) < pq);
        tick();
      end
      quiet(); repeat (3) tick();
    end

    quiet(); repeat (4) tick();
    chk("sb_drain", expq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
